// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding RISC-V load/store with a fixed LATENCY.
// Define DMEM_ERR_EN to flag misaligned/illegal-width accesses; otherwise the sub-size address bits are ignored.
module dmem_responder #(
    parameter int ADDR_W  = 17,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [2:0]  req_width,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [2:0]  width_q, width_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        busy_q, busy_d;

    logic [31:0] mem [0:(1 << ADDR_W) - 1];

    logic [31:0]       op_addr, op_wdata;
    logic              op_we, op_err;
    logic [2:0]        op_width;
    logic              fire, mem_we;
    logic              is_byte, is_half;
    logic [1:0]        lane;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_rep, rd_word, rd_shift, ld_data;
    logic [ADDR_W-1:0] idx;
    logic              unused_addr_bits;

    // With LATENCY=1 the access fires on the accept edge, so it must use the live request.
    assign op_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign op_we    = (state_q == S_IDLE) ? req_we    : we_q;
    assign op_width = (state_q == S_IDLE) ? req_width : width_q;
    assign op_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

    assign idx              = op_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^op_addr[31:ADDR_W+2];
    assign is_byte          = (op_width[1:0] == 2'b00);
    assign is_half          = (op_width[1:0] == 2'b01);

    always_comb begin
`ifdef DMEM_ERR_EN
        lane   = op_addr[1:0];
        op_err = (op_width == 3'b011) || (op_width[2:1] == 2'b11) ||
                 (is_half && op_addr[0]) ||
                 ((op_width == 3'b010) && (op_addr[1:0] != 2'b00));
`else
        op_err = 1'b0;
        if (is_byte)      lane = op_addr[1:0];
        else if (is_half) lane = {op_addr[1], 1'b0};
        else              lane = 2'b00;
`endif
    end

    // Store data is replicated into every lane; the byte enables pick the live ones.
    always_comb begin
        if (is_byte) begin
            byte_en   = 4'b0001 << lane;
            wdata_rep = {4{op_wdata[7:0]}};
        end else if (is_half) begin
            byte_en   = 4'b0011 << lane;
            wdata_rep = {2{op_wdata[15:0]}};
        end else begin
            byte_en   = 4'b1111;
            wdata_rep = op_wdata;
        end
    end

    assign rd_word  = mem[idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        case (op_width)
            3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  ld_data = {24'd0, rd_shift[7:0]};
            3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  ld_data = {16'd0, rd_shift[15:0]};
            default: ld_data = rd_shift;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        width_d     = width_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        fire        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    width_d = req_width;
                    wdata_d = req_wdata;
                    if (LATENCY == 1) begin
                        fire    = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    fire    = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (fire) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = op_err;
            rsp_rdata_d = (op_we || op_err) ? 32'd0 : ld_data;
        end

        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    assign mem_we = fire && op_we && !op_err && !rst;

    // NOTE: storage has no reset; its contents must survive rst, and a reset loop would block RAM inference.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            we_q        <= 1'b0;
            width_q     <= 3'd0;
            wdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            width_q     <= width_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the core's load/store request interface.
- Accepts one request at a time over a valid/ready handshake and models a fixed access latency.
- Performs RISC-V byte/half/word stores with lane selection; returns sign- or zero-extended loads.
- Flags misaligned or illegal-width accesses. Replaces the zero-latency array so the pipeline's stall path is exercised.

Parameters:
- ADDR_W, 17, word-address bits; depth = 2**ADDR_W words of 32 bits.
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high, sampled on posedge clk.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_width  in  3  funct3 encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_wdata  in  32  store data, right-aligned (bits 7:0 for b, 15:0 for h).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access rejected (valid only with rsp_valid).
- busy  out  1  request in flight (state != IDLE); drives core stall.

Behaviour:
- Reset: state IDLE, counter 0, all latched request fields 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
- Array contents are not cleared by reset.
- Reset wins over every other event in the same cycle.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid at posedge, latch addr/we/width/wdata.
  - LATENCY=1: go to RESP.
  - Otherwise load counter with LATENCY-2 and go to WAIT.
- WAIT: req_ready=0. Counter decrements each cycle; when it is 0, go to RESP.
- RESP: req_ready=0, rsp_valid=1 for exactly one cycle, then go to IDLE.
  - Response data and error are registered and held stable through the RESP cycle.
  - Core has no response backpressure.
- Timing: request accepted at edge E0 gives rsp_valid high during the cycle after edge E(LATENCY); req_ready returns high one cycle later.
- Throughput: one request per LATENCY+1 cycles.
- Word index = addr[ADDR_W+1:2]. Higher address bits are ignored, so accesses wrap modulo the depth.
- Errors:
  - Misaligned: h/hu with addr[0]=1, or w with addr[1:0]!=0.
  - Illegal width: 011, 110, 111.
  - Effect: rsp_err=1, rsp_rdata=0, and no array write.
- Stores: array written on the edge entering RESP. Byte mask is 0001<<addr[1:0] for b, 0011<<addr[1:0] for h, 1111 for w. Data is replicated into lanes. Unmasked bytes are unchanged.
- Loads: word read on the edge entering RESP. Lane = addr[1:0].
  - b/h are sign-extended; bu/hu are zero-extended; w is passed through.
  - A store immediately followed by a load to the same word returns the new data.
- Reset during WAIT aborts the request: no write, no response.
- req_valid while req_ready=0 is ignored. The core must hold the request until accepted.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined: misalignment and illegal-width detection as above.
- Undefined:
  - rsp_err is tied 0.
  - Low address bits below access size are forced to zero (h ignores addr[0]; w ignores addr[1:0]).
  - Illegal widths behave as w.

Test Plan:
- Reset, then sw 0x12345678 @0x100 (LATENCY=2) -> req_ready low after acceptance; rsp_valid exactly 2 cycles after the accept edge; rsp_err=0; req_ready high the next cycle.
- After that store: lb @0x101 -> 0x00000056; lbu @0x103 -> 0x00000012; lh @0x102 -> 0x00001234; lw @0x100 -> 0x12345678.
- sb 0xF0 @0x102, then lw @0x100 -> 0x12F05678; lb @0x102 -> 0xFFFFFFF0; lhu @0x102 -> 0x000012F0.
- With DMEM_ERR_EN: lw @0x101 -> rsp_err=1, rsp_rdata=0. sh 0xBEEF @0x103 -> rsp_err=1; subsequent lw @0x100 -> unchanged.
- sw 0xDEADBEEF @0x104 with rst asserted in the WAIT cycle -> no rsp_valid; lw @0x104 returns the prior value. Separately, address 0x00080004 aliases 0x4 (ADDR_W=17).
- LATENCY=1 build: back-to-back sw/lw @0x200 (0xCAFEF00D) -> each response 1 cycle after accept; load returns 0xCAFEF00D; busy high only during RESP.
